// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the zy_CPU multi-cycle control unit:
// FSM states, instruction classes, opcodes and the ALU_*/IMM_* codes.
package multicycle_control_unit_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_ALU,
      CLS_MEXT,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_UPPER
   } instr_class_t;

   // Only the fields that steer control are kept in the instruction register.
   typedef struct packed {
      logic [6:0] funct7;
      logic [2:0] funct3;
      logic [6:0] opcode;
   } ir_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_SLL  = 5'd2;
   localparam logic [4:0] ALU_SLT  = 5'd3;
   localparam logic [4:0] ALU_SLTU = 5'd4;
   localparam logic [4:0] ALU_XOR  = 5'd5;
   localparam logic [4:0] ALU_SRL  = 5'd6;
   localparam logic [4:0] ALU_SRA  = 5'd7;
   localparam logic [4:0] ALU_OR   = 5'd8;
   localparam logic [4:0] ALU_AND  = 5'd9;
   localparam logic [4:0] ALU_LUI  = 5'd10;
   localparam logic [4:0] ALU_MUL  = 5'd16;
   localparam logic [4:0] ALU_DIV  = 5'd20;

   localparam logic [3:0] IMM_R = 4'd0;
   localparam logic [3:0] IMM_I = 4'd1;
   localparam logic [3:0] IMM_S = 4'd2;
   localparam logic [3:0] IMM_B = 4'd3;
   localparam logic [3:0] IMM_U = 4'd4;
   localparam logic [3:0] IMM_J = 4'd5;

   // alt selects SUB/SRA for the two funct3 codes that have an alternate form
   function automatic logic [4:0] alu_base_op(input logic [2:0] funct3, input logic alt);
      logic [4:0] op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_instr_decoder.sv
// Combinational decode of the latched instruction fields into ALU op, immediate
// format, instruction class and an illegal flag. ZY_MEXT_EN enables MUL/DIV decode.
module instr_decoder
   import multicycle_control_unit_pkg::*;
(
   input  ir_t          ir,
   output logic [4:0]   alu_op,
   output logic [3:0]   imm_sel,
   output instr_class_t instr_class,
   output logic         illegal
);

   always_comb begin
      alu_op      = ALU_ADD;
      imm_sel     = IMM_R;
      instr_class = CLS_NONE;
      illegal     = 1'b0;
      case (ir.opcode)
         OPC_OP: begin
            instr_class = CLS_ALU;
            if (ir.funct7 == F7_BASE) begin
               alu_op = alu_base_op(ir.funct3, 1'b0);
            end else if (ir.funct7 == F7_ALT && (ir.funct3 == 3'b000 || ir.funct3 == 3'b101)) begin
               alu_op = alu_base_op(ir.funct3, 1'b1);
            end else if (ir.funct7 == F7_MEXT) begin
               instr_class = CLS_MEXT;
               alu_op = ir.funct3[2] ? (ALU_DIV | {3'b000, ir.funct3[1:0]})
                                     : (ALU_MUL | {3'b000, ir.funct3[1:0]});
`ifndef ZY_MEXT_EN
               illegal = 1'b1;
`endif
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            instr_class = CLS_ALU;
            imm_sel     = IMM_I;
            // Shift-immediates reuse the funct7 slot, so only those two codes are checked
            if (ir.funct3 == 3'b001) begin
               alu_op  = ALU_SLL;
               illegal = (ir.funct7 != F7_BASE);
            end else if (ir.funct3 == 3'b101) begin
               alu_op  = (ir.funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
               illegal = (ir.funct7 != F7_BASE) && (ir.funct7 != F7_ALT);
            end else begin
               alu_op = alu_base_op(ir.funct3, 1'b0);
            end
         end
         OPC_LOAD: begin
            instr_class = CLS_LOAD;
            imm_sel     = IMM_I;
            illegal     = (ir.funct3 == 3'b011) || (ir.funct3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            instr_class = CLS_STORE;
            imm_sel     = IMM_S;
            illegal     = ir.funct3[2] || (ir.funct3[1:0] == 2'b11);
         end
         OPC_BRANCH: begin
            instr_class = CLS_BRANCH;
            imm_sel     = IMM_B;
            illegal     = (ir.funct3[2:1] == 2'b01);
         end
         OPC_JAL: begin
            instr_class = CLS_JUMP;
            imm_sel     = IMM_J;
         end
         OPC_JALR: begin
            instr_class = CLS_JUMP;
            imm_sel     = IMM_I;
            illegal     = (ir.funct3 != 3'b000);
         end
         OPC_LUI: begin
            instr_class = CLS_UPPER;
            imm_sel     = IMM_U;
            alu_op      = ALU_LUI;
         end
         OPC_AUIPC: begin
            instr_class = CLS_UPPER;
            imm_sel     = IMM_U;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for zy_CPU: fetch/decode/exec/mem/writeback sequencing with
// memory wait timeout and illegal trap. Define ZY_MEXT_EN for MUL/DIV with i_alu_done stall.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int INSTR_W      = 32,
   parameter int ALU_OP_W     = 5,
   parameter int IMM_SEL_W    = 4,
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [INSTR_W-1:0]   i_instr,
   input  logic                 i_imem_ready,
   input  logic                 i_dmem_ready,
   input  logic                 i_br_taken,
   input  logic                 i_alu_done,
   output logic                 o_imem_req,
   output logic                 o_ir_we,
   output logic                 o_pc_we,
   output logic                 o_pc_sel,
   output logic                 o_regw,
   output logic                 o_memr,
   output logic                 o_memw,
   output logic [ALU_OP_W-1:0]  o_alu_op,
   output logic [IMM_SEL_W-1:0] o_imm_sel,
   output logic [2:0]           o_state,
   output logic                 o_illegal,
   output logic                 o_timeout
);

   localparam int CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

   state_t           state, state_next;
   ir_t              ir;
   logic [CNT_W-1:0] wait_cnt;
   logic             illegal_q, timeout_q;
   logic             ir_load, wait_active, wait_limit, timeout_hit;
   logic [4:0]       dec_alu_op;
   logic [3:0]       dec_imm_sel;
   instr_class_t     dec_class;
   logic             dec_illegal;
   logic             instr_unused;

   instr_decoder u_decoder (
      .ir          (ir),
      .alu_op      (dec_alu_op),
      .imm_sel     (dec_imm_sel),
      .instr_class (dec_class),
      .illegal     (dec_illegal)
   );

   assign ir_load      = (state == S_FETCH) && i_imem_ready;
   assign wait_limit   = (MEM_WAIT_MAX != 0) && (wait_cnt == CNT_W'(MEM_WAIT_MAX));
   assign instr_unused = ^{i_instr[24:15], i_instr[11:7]};

`ifndef ZY_MEXT_EN
   logic alu_done_unused;
   assign alu_done_unused = i_alu_done;
`endif

   // Next-state logic; a ready arriving on the limit cycle wins over the timeout
   always_comb begin
      state_next  = state;
      wait_active = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         S_FETCH: begin
            if (i_imem_ready) begin
               state_next = S_DECODE;
            end else begin
               wait_active = 1'b1;
               if (wait_limit) begin
                  timeout_hit = 1'b1;
                  state_next  = S_TRAP;
               end
            end
         end
         S_DECODE: state_next = dec_illegal ? S_TRAP : S_EXEC;
         S_EXEC: begin
            case (dec_class)
               CLS_BRANCH:          state_next = S_FETCH;
               CLS_LOAD, CLS_STORE: state_next = S_MEM;
`ifdef ZY_MEXT_EN
               CLS_MEXT:            if (i_alu_done) state_next = S_WB;
`endif
               default:             state_next = S_WB;
            endcase
         end
         S_MEM: begin
            if (i_dmem_ready) begin
               state_next = (dec_class == CLS_LOAD) ? S_WB : S_FETCH;
            end else begin
               wait_active = 1'b1;
               if (wait_limit) begin
                  timeout_hit = 1'b1;
                  state_next  = S_TRAP;
               end
            end
         end
         S_WB:    state_next = S_FETCH;
         S_TRAP:  state_next = S_TRAP;
         default: state_next = S_FETCH;
      endcase
   end

   // State, instruction register, wait counter and sticky trap flags
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= S_FETCH;
         ir        <= '0;
         wait_cnt  <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state <= state_next;
         if (ir_load) ir <= {i_instr[31:25], i_instr[14:12], i_instr[6:0]};
         if (state_next != state) wait_cnt <= '0;
         else if (wait_active)    wait_cnt <= wait_cnt + CNT_W'(1);
         if (state == S_DECODE && dec_illegal) illegal_q <= 1'b1;
         if (timeout_hit) timeout_q <= 1'b1;
      end
   end

   // PC strobes: branches resolve in EXEC, stores advance once the write lands
   always_comb begin
      o_pc_we  = 1'b0;
      o_pc_sel = 1'b0;
      case (state)
         S_EXEC: begin
            if (dec_class == CLS_BRANCH) begin
               o_pc_we  = 1'b1;
               o_pc_sel = i_br_taken;
            end
         end
         S_MEM: begin
            if (dec_class == CLS_STORE && i_dmem_ready) o_pc_we = 1'b1;
         end
         S_WB: begin
            o_pc_we  = 1'b1;
            o_pc_sel = (dec_class == CLS_JUMP);
         end
         default: ;
      endcase
   end

   assign o_imem_req = i_rst | (state == S_FETCH);
   assign o_ir_we    = ir_load & ~i_rst;
   assign o_regw     = (state == S_WB);
   assign o_memr     = (state == S_MEM) && (dec_class == CLS_LOAD);
   assign o_memw     = (state == S_MEM) && (dec_class == CLS_STORE);
   assign o_alu_op   = (state == S_EXEC || state == S_MEM || state == S_WB) ? ALU_OP_W'(dec_alu_op)   : '0;
   assign o_imm_sel  = (state == S_EXEC || state == S_MEM || state == S_WB) ? IMM_SEL_W'(dec_imm_sel) : '0;
   assign o_state    = state;
   assign o_illegal  = illegal_q;
   assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit with hand-computed expectations.
module tb_multicycle_control_unit;

   localparam logic [2:0]  ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2;
   localparam logic [2:0]  ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd5;
   localparam logic [4:0]  OP_ADD = 5'd0, OP_SUB = 5'd1, OP_LUI = 5'd10, OP_MUL = 5'd16;
   localparam logic [3:0]  IS_R = 4'd0, IS_I = 4'd1, IS_S = 4'd2, IS_B = 4'd3, IS_U = 4'd4, IS_J = 4'd5;
   localparam logic [31:0] I_ADD = 32'h002081B3, I_SUB = 32'h402081B3, I_LW = 32'h0000A283;
   localparam logic [31:0] I_SW = 32'h0020A023, I_BEQ = 32'h00208463, I_JAL = 32'h000000EF;
   localparam logic [31:0] I_LUI = 32'h123452B7, I_ADDI = 32'h00500093, I_BAD_OPC = 32'h0000007F;
   localparam logic [31:0] I_BAD_F7 = 32'h402091B3, I_MUL = 32'h022081B3;

   logic        i_clk, i_rst, i_imem_ready, i_dmem_ready, i_br_taken, i_alu_done;
   logic [31:0] i_instr;
   logic        o_imem_req, o_ir_we, o_pc_we, o_pc_sel, o_regw, o_memr, o_memw;
   logic [4:0]  o_alu_op;
   logic [3:0]  o_imm_sel;
   logic [2:0]  o_state;
   logic        o_illegal, o_timeout;

   int vectors = 0;
   int miscompares = 0;

   multicycle_control_unit dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr), .i_imem_ready(i_imem_ready),
      .i_dmem_ready(i_dmem_ready), .i_br_taken(i_br_taken), .i_alu_done(i_alu_done),
      .o_imem_req(o_imem_req), .o_ir_we(o_ir_we), .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel),
      .o_regw(o_regw), .o_memr(o_memr), .o_memw(o_memw), .o_alu_op(o_alu_op),
      .o_imm_sel(o_imm_sel), .o_state(o_state), .o_illegal(o_illegal), .o_timeout(o_timeout)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] instr);
      i_instr = instr;
      i_imem_ready = 1'b1;
      step();
      i_imem_ready = 1'b0;
      i_instr = 32'hFFFF_FFFF;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_imem_ready = 1'b0; i_dmem_ready = 1'b0; i_br_taken = 1'b0; i_alu_done = 1'b0;
      step(); step();
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_imem_ready = 1'b1; i_dmem_ready = 1'b1; i_br_taken = 1'b1; i_alu_done = 1'b0;
      i_instr = I_ADD;
      step(); step(); #1;
      vectors++; if (o_state !== ST_FETCH) begin miscompares++; $display("[TB] FAIL reset_state: got %0d want %0d", o_state, ST_FETCH); end
      vectors++; if (o_imem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_imem_req: got %b want 1", o_imem_req); end
      vectors++; if (o_ir_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ir_we: got %b want 0", o_ir_we); end
      vectors++; if ({o_regw, o_pc_we, o_pc_sel, o_memr, o_memw} !== 5'b0) begin miscompares++; $display("[TB] FAIL reset_strobes: got %b want 00000", {o_regw, o_pc_we, o_pc_sel, o_memr, o_memw}); end
      vectors++; if (o_alu_op !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_alu_op: got %0d want 0", o_alu_op); end
      vectors++; if (o_imm_sel !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_imm_sel: got %0d want 0", o_imm_sel); end
      vectors++; if ({o_illegal, o_timeout} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_flags: got %b want 00", {o_illegal, o_timeout}); end
      i_rst = 1'b0; i_imem_ready = 1'b0; i_dmem_ready = 1'b0; i_br_taken = 1'b0;
   endtask

   task automatic test_back_to_back();
      i_instr = I_ADD; i_imem_ready = 1'b1; #1;
      vectors++; if (o_ir_we !== 1'b1) begin miscompares++; $display("[TB] FAIL add_ir_we: got %b want 1", o_ir_we); end
      step(); i_imem_ready = 1'b0; i_instr = 32'hFFFF_FFFF; #1;
      vectors++; if (o_state !== ST_DECODE) begin miscompares++; $display("[TB] FAIL add_decode_state: got %0d want %0d", o_state, ST_DECODE); end
      vectors++; if (o_regw !== 1'b0) begin miscompares++; $display("[TB] FAIL add_decode_regw: got %b want 0", o_regw); end
      step(); #1;
      vectors++; if (o_state !== ST_EXEC) begin miscompares++; $display("[TB] FAIL add_exec_state: got %0d want %0d", o_state, ST_EXEC); end
      vectors++; if (o_alu_op !== OP_ADD) begin miscompares++; $display("[TB] FAIL add_exec_alu_op: got %0d want %0d", o_alu_op, OP_ADD); end
      vectors++; if (o_imm_sel !== IS_R) begin miscompares++; $display("[TB] FAIL add_exec_imm_sel: got %0d want %0d", o_imm_sel, IS_R); end
      vectors++; if (o_regw !== 1'b0) begin miscompares++; $display("[TB] FAIL add_exec_regw: got %b want 0", o_regw); end
      step(); #1;
      vectors++; if (o_state !== ST_WB) begin miscompares++; $display("[TB] FAIL add_wb_state: got %0d want %0d", o_state, ST_WB); end
      vectors++; if ({o_regw, o_pc_we, o_pc_sel} !== 3'b110) begin miscompares++; $display("[TB] FAIL add_wb_strobes: got %b want 110", {o_regw, o_pc_we, o_pc_sel}); end
      vectors++; if (o_alu_op === OP_SUB) begin miscompares++; $display("[TB] FAIL add_wb_alu_op: got %0d want not %0d", o_alu_op, OP_SUB); end
      step(); i_instr = I_SUB; i_imem_ready = 1'b1; #1;
      vectors++; if (o_state !== ST_FETCH) begin miscompares++; $display("[TB] FAIL b2b_fetch_state: got %0d want %0d", o_state, ST_FETCH); end
      vectors++; if ({o_ir_we, o_regw} !== 2'b10) begin miscompares++; $display("[TB] FAIL b2b_fetch_strobes: got %b want 10", {o_ir_we, o_regw}); end
      step(); i_imem_ready = 1'b0; i_instr = 32'hFFFF_FFFF;
      step(); #1;
      vectors++; if (o_alu_op !== OP_SUB) begin miscompares++; $display("[TB] FAIL sub_exec_alu_op: got %0d want %0d", o_alu_op, OP_SUB); end
      step(); step(); #1;
      vectors++; if (o_state !== ST_FETCH) begin miscompares++; $display("[TB] FAIL sub_done_state: got %0d want %0d", o_state, ST_FETCH); end
   endtask

   task automatic test_load_wait();
      fetch(I_LW);
      step(); #1;
      vectors++; if ({o_state, o_imm_sel, o_alu_op} !== {ST_EXEC, IS_I, OP_ADD}) begin miscompares++; $display("[TB] FAIL lw_exec: got %h want %h", {o_state, o_imm_sel, o_alu_op}, {ST_EXEC, IS_I, OP_ADD}); end
      step();
      for (int k = 0; k < 4; k++) begin
         i_dmem_ready = (k == 3); #1;
         vectors++; if ({o_state, o_memr, o_regw, o_pc_we} !== {ST_MEM, 3'b100}) begin miscompares++; $display("[TB] FAIL lw_mem_cycle%0d: got %b want %b", k, {o_state, o_memr, o_regw, o_pc_we}, {ST_MEM, 3'b100}); end
         step();
      end
      i_dmem_ready = 1'b0; #1;
      vectors++; if ({o_state, o_regw, o_memr} !== {ST_WB, 2'b10}) begin miscompares++; $display("[TB] FAIL lw_wb: got %b want %b", {o_state, o_regw, o_memr}, {ST_WB, 2'b10}); end
      step(); #1;
      vectors++; if (o_state !== ST_FETCH) begin miscompares++; $display("[TB] FAIL lw_done_state: got %0d want %0d", o_state, ST_FETCH); end
   endtask

   task automatic test_store();
      fetch(I_SW);
      step(); #1;
      vectors++; if (o_imm_sel !== IS_S) begin miscompares++; $display("[TB] FAIL sw_exec_imm_sel: got %0d want %0d", o_imm_sel, IS_S); end
      step(); i_dmem_ready = 1'b1; #1;
      vectors++; if ({o_state, o_memw, o_memr, o_pc_we, o_pc_sel, o_regw} !== {ST_MEM, 5'b10100}) begin miscompares++; $display("[TB] FAIL sw_mem: got %b want %b", {o_state, o_memw, o_memr, o_pc_we, o_pc_sel, o_regw}, {ST_MEM, 5'b10100}); end
      step(); i_dmem_ready = 1'b0; #1;
      vectors++; if ({o_state, o_memw} !== {ST_FETCH, 1'b0}) begin miscompares++; $display("[TB] FAIL sw_done: got %b want %b", {o_state, o_memw}, {ST_FETCH, 1'b0}); end
   endtask

   task automatic test_branch();
      fetch(I_BEQ);
      step(); i_br_taken = 1'b1; #1;
      vectors++; if ({o_state, o_pc_we, o_pc_sel, o_regw} !== {ST_EXEC, 3'b110}) begin miscompares++; $display("[TB] FAIL beq_exec_taken: got %b want %b", {o_state, o_pc_we, o_pc_sel, o_regw}, {ST_EXEC, 3'b110}); end
      vectors++; if (o_imm_sel !== IS_B) begin miscompares++; $display("[TB] FAIL beq_imm_sel: got %0d want %0d", o_imm_sel, IS_B); end
      i_br_taken = 1'b0; #1;
      vectors++; if (o_pc_sel !== 1'b0) begin miscompares++; $display("[TB] FAIL beq_not_taken_sel: got %b want 0", o_pc_sel); end
      i_br_taken = 1'b1;
      step(); i_br_taken = 1'b0; #1;
      vectors++; if ({o_state, o_regw, o_pc_we} !== {ST_FETCH, 2'b00}) begin miscompares++; $display("[TB] FAIL beq_done: got %b want %b", {o_state, o_regw, o_pc_we}, {ST_FETCH, 2'b00}); end
   endtask

   task automatic test_jump_upper();
      fetch(I_JAL);
      step(); #1;
      vectors++; if ({o_imm_sel, o_alu_op} !== {IS_J, OP_ADD}) begin miscompares++; $display("[TB] FAIL jal_exec: got %h want %h", {o_imm_sel, o_alu_op}, {IS_J, OP_ADD}); end
      step(); #1;
      vectors++; if ({o_state, o_regw, o_pc_we, o_pc_sel} !== {ST_WB, 3'b111}) begin miscompares++; $display("[TB] FAIL jal_wb: got %b want %b", {o_state, o_regw, o_pc_we, o_pc_sel}, {ST_WB, 3'b111}); end
      step();
      fetch(I_LUI);
      step(); #1;
      vectors++; if ({o_imm_sel, o_alu_op} !== {IS_U, OP_LUI}) begin miscompares++; $display("[TB] FAIL lui_exec: got %h want %h", {o_imm_sel, o_alu_op}, {IS_U, OP_LUI}); end
      step(); #1;
      vectors++; if ({o_regw, o_pc_sel} !== 2'b10) begin miscompares++; $display("[TB] FAIL lui_wb: got %b want 10", {o_regw, o_pc_sel}); end
      step();
   endtask

   task automatic test_timeout();
      i_imem_ready = 1'b0;
      for (int k = 0; k < 15; k++) step();
      #1;
      vectors++; if ({o_state, o_timeout} !== {ST_FETCH, 1'b0}) begin miscompares++; $display("[TB] FAIL fetch_timeout_limit: got %b want %b", {o_state, o_timeout}, {ST_FETCH, 1'b0}); end
      step(); #1;
      vectors++; if ({o_state, o_timeout, o_imem_req} !== {ST_TRAP, 2'b10}) begin miscompares++; $display("[TB] FAIL fetch_timeout_trap: got %b want %b", {o_state, o_timeout, o_imem_req}, {ST_TRAP, 2'b10}); end
      do_reset(); #1;
      vectors++; if (o_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_cleared: got %b want 0", o_timeout); end
      for (int k = 0; k < 15; k++) step();
      i_instr = I_ADDI; i_imem_ready = 1'b1; #1;
      vectors++; if (o_ir_we !== 1'b1) begin miscompares++; $display("[TB] FAIL ready_at_limit_ir_we: got %b want 1", o_ir_we); end
      step(); i_imem_ready = 1'b0; #1;
      vectors++; if ({o_state, o_timeout} !== {ST_DECODE, 1'b0}) begin miscompares++; $display("[TB] FAIL ready_at_limit_no_trap: got %b want %b", {o_state, o_timeout}, {ST_DECODE, 1'b0}); end
      step(); #1;
      vectors++; if (o_imm_sel !== IS_I) begin miscompares++; $display("[TB] FAIL addi_imm_sel: got %0d want %0d", o_imm_sel, IS_I); end
      step(); step();
      fetch(I_LW);
      step(); step();
      for (int k = 0; k < 15; k++) step();
      #1;
      vectors++; if ({o_state, o_memr} !== {ST_MEM, 1'b1}) begin miscompares++; $display("[TB] FAIL mem_timeout_limit: got %b want %b", {o_state, o_memr}, {ST_MEM, 1'b1}); end
      step(); #1;
      vectors++; if ({o_state, o_timeout, o_memr, o_regw} !== {ST_TRAP, 3'b100}) begin miscompares++; $display("[TB] FAIL mem_timeout_trap: got %b want %b", {o_state, o_timeout, o_memr, o_regw}, {ST_TRAP, 3'b100}); end
      do_reset();
   endtask

   task automatic test_illegal();
      fetch(I_BAD_OPC); #1;
      vectors++; if ({o_state, o_illegal} !== {ST_DECODE, 1'b0}) begin miscompares++; $display("[TB] FAIL bad_opc_decode: got %b want %b", {o_state, o_illegal}, {ST_DECODE, 1'b0}); end
      step(); #1;
      vectors++; if ({o_state, o_illegal} !== {ST_TRAP, 1'b1}) begin miscompares++; $display("[TB] FAIL bad_opc_trap: got %b want %b", {o_state, o_illegal}, {ST_TRAP, 1'b1}); end
      i_imem_ready = 1'b1;
      step(); step(); #1;
      vectors++; if ({o_state, o_illegal, o_ir_we, o_imem_req, o_regw} !== {ST_TRAP, 4'b1000}) begin miscompares++; $display("[TB] FAIL trap_stuck: got %b want %b", {o_state, o_illegal, o_ir_we, o_imem_req, o_regw}, {ST_TRAP, 4'b1000}); end
      i_rst = 1'b1; #1;
      vectors++; if ({o_state, o_illegal, o_timeout} !== {ST_FETCH, 2'b00}) begin miscompares++; $display("[TB] FAIL trap_async_reset: got %b want %b", {o_state, o_illegal, o_timeout}, {ST_FETCH, 2'b00}); end
      step(); i_rst = 1'b0; i_imem_ready = 1'b0;
      fetch(I_BAD_F7);
      step(); #1;
      vectors++; if ({o_state, o_illegal} !== {ST_TRAP, 1'b1}) begin miscompares++; $display("[TB] FAIL bad_funct7_trap: got %b want %b", {o_state, o_illegal}, {ST_TRAP, 1'b1}); end
      do_reset();
   endtask

   task automatic test_mext();
      fetch(I_MUL);
      step(); #1;
`ifdef ZY_MEXT_EN
      vectors++; if ({o_state, o_alu_op} !== {ST_EXEC, OP_MUL}) begin miscompares++; $display("[TB] FAIL mul_exec: got %h want %h", {o_state, o_alu_op}, {ST_EXEC, OP_MUL}); end
      for (int k = 0; k < 5; k++) begin
         i_alu_done = (k == 4); #1;
         vectors++; if ({o_state, o_regw} !== {ST_EXEC, 1'b0}) begin miscompares++; $display("[TB] FAIL mul_hold%0d: got %b want %b", k, {o_state, o_regw}, {ST_EXEC, 1'b0}); end
         step();
      end
      i_alu_done = 1'b0; #1;
      vectors++; if ({o_state, o_regw} !== {ST_WB, 1'b1}) begin miscompares++; $display("[TB] FAIL mul_wb: got %b want %b", {o_state, o_regw}, {ST_WB, 1'b1}); end
      step();
`else
      vectors++; if ({o_state, o_illegal} !== {ST_TRAP, 1'b1}) begin miscompares++; $display("[TB] FAIL mul_illegal: got %b want %b", {o_state, o_illegal}, {ST_TRAP, 1'b1}); end
      vectors++; if (o_alu_op === OP_MUL) begin miscompares++; $display("[TB] FAIL mul_alu_op: got %0d want not %0d", o_alu_op, OP_MUL); end
      do_reset();
`endif
   endtask

   task automatic test_abort();
      fetch(I_SW);
      step(); step(); #1;
      vectors++; if ({o_state, o_memw} !== {ST_MEM, 1'b1}) begin miscompares++; $display("[TB] FAIL abort_pre_memw: got %b want %b", {o_state, o_memw}, {ST_MEM, 1'b1}); end
      i_rst = 1'b1; #1;
      vectors++; if ({o_state, o_memw, o_pc_we} !== {ST_FETCH, 2'b00}) begin miscompares++; $display("[TB] FAIL abort_reset: got %b want %b", {o_state, o_memw, o_pc_we}, {ST_FETCH, 2'b00}); end
      step(); i_rst = 1'b0; i_dmem_ready = 1'b1;
      step(); step(); #1;
      vectors++; if ({o_state, o_memw, o_regw} !== {ST_FETCH, 2'b00}) begin miscompares++; $display("[TB] FAIL abort_after: got %b want %b", {o_state, o_memw, o_regw}, {ST_FETCH, 2'b00}); end
      i_dmem_ready = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1; i_instr = 32'h0; i_imem_ready = 1'b0; i_dmem_ready = 1'b0;
      i_br_taken = 1'b0; i_alu_done = 1'b0;
      test_reset();
      test_back_to_back();
      test_load_wait();
      test_store();
      test_branch();
      test_jump_upper();
      test_timeout();
      test_illegal();
      test_mext();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle control FSM for the zy_CPU core. It sequences each instruction through fetch, decode, execute, memory and writeback. It latches the fetched instruction and drives per-state datapath enables, with ready handshakes to instruction and data memory. It also provides a wait-state timeout and an illegal-instruction trap. It sits between the memories and the datapath (regfile, ALU, PC, immediate generator), and supersedes the single-cycle combinational decode.

## Interface
Parameters:
- INSTR_W, 32, instruction width
- ALU_OP_W, 5, ALU opcode width (matches ALU_OP)
- IMM_SEL_W, 4, immediate-select width (matches IMM_SEL)
- MEM_WAIT_MAX, 15, max wait cycles for a memory ready; 0 disables timeout

Ports (one clock; reset is asynchronous and active-high):
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_instr  in  INSTR_W  instruction from imem; valid when i_imem_ready=1
- i_imem_ready  in  1  fetch complete
- i_dmem_ready  in  1  data access complete
- i_br_taken  in  1  branch condition from datapath comparator
- i_alu_done  in  1  multi-cycle ALU result ready (used only with ZY_MEXT_EN)
- o_imem_req  out  1  fetch request
- o_ir_we  out  1  instruction register load strobe
- o_pc_we  out  1  PC update strobe
- o_pc_sel  out  1  0 = PC+4, 1 = branch/jump target
- o_regw  out  1  register write strobe
- o_memr  out  1  data read request
- o_memw  out  1  data write request
- o_alu_op  out  ALU_OP_W  ALU operation
- o_imm_sel  out  IMM_SEL_W  immediate format
- o_state  out  3  current state (debug)
- o_illegal  out  1  sticky illegal-instruction trap
- o_timeout  out  1  sticky memory-timeout trap

## Operation
- Internal IR: holds opcode, funct3 and funct7. It loads from i_instr in the cycle o_ir_we=1. All decode (alu_op, imm_sel, class) comes from the IR, never from i_instr.
- States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP.
- S_FETCH:
  - o_imem_req=1.
  - On i_imem_ready: o_ir_we=1 and go to S_DECODE.
- S_DECODE:
  - Unsupported opcode, or an R/I funct combination the ALU does not implement: go to S_TRAP and set o_illegal.
  - Otherwise go to S_EXEC.
- S_EXEC:
  - o_alu_op and o_imm_sel are valid.
  - Branch: o_pc_we=1, o_pc_sel=i_br_taken, then go to S_FETCH.
  - Load or store: go to S_MEM.
  - R, I, LUI, AUIPC, JAL, JALR: go to S_WB.
- S_MEM:
  - Hold o_memr (load) or o_memw (store) until i_dmem_ready.
  - Load: go to S_WB.
  - Store: o_pc_we=1, o_pc_sel=0, then go to S_FETCH.
- S_WB:
  - o_regw=1 for exactly one cycle and o_pc_we=1.
  - o_pc_sel=1 for JAL/JALR, else 0.
  - Go to S_FETCH.
- S_TRAP:
  - All strobes are 0 and o_illegal/o_timeout are held.
  - Only reset exits this state.
- Wait counter: width $clog2(MEM_WAIT_MAX+1). It clears on entry to S_FETCH/S_MEM and increments each cycle in those states while the ready input is 0. When it equals MEM_WAIT_MAX with ready still 0, go to S_TRAP and set o_timeout.
- Ready asserted in the same cycle the counter reaches its limit: ready wins and no timeout is raised.
- ALU opcode and imm_sel encodings are the shared ALU_*/IMM_* constants. o_alu_op=ALU_ADD for load, store, AUIPC, JAL and JALR.

## Timing
- Reset values: state S_FETCH, IR 0, counter 0, o_illegal=0, o_timeout=0, all strobes 0, o_alu_op=0, o_imm_sel=0.
- Reset mid-instruction aborts it immediately; no regw/memw is issued afterward.
- Strobes are Moore outputs of state plus IR, except:
  - o_ir_we and o_pc_sel, which depend on the i_imem_ready / i_br_taken inputs of that cycle;
  - o_imem_req, which is 1 during reset.
- Zero-wait latency in cycles:
  - ALU/jump/LUI: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
- Each wait cycle on a ready adds one cycle.
- Back-to-back instructions: S_FETCH follows with no bubble.

## Configuration
- ZY_MEXT_EN defined:
  - R-type with funct7=0000001 decodes to ALU_MUL/ALU_DIV group codes.
  - S_EXEC holds until i_alu_done=1, with no timeout, before going to S_WB.
- ZY_MEXT_EN undefined:
  - funct7=0000001 traps as illegal.
  - i_alu_done is ignored.

## Structure
- define.svh gains the state enum (S_FETCH..S_TRAP), the opcode constants, and ALU_MUL/ALU_DIV codes.
- One sub-module, instr_decoder: combinational IR → {alu_op, imm_sel, class, illegal}. The FSM, IR and counter live in multicycle_control_unit.

## Test plan
- ADD x3,x1,x2 (0x002081B3) with zero-wait imem → states FETCH, DECODE, EXEC, WB; o_alu_op=ALU_SUB never appears; o_regw=1 in cycle 4 only.
- LW with i_dmem_ready delayed 3 cycles → o_memr high for 4 cycles, then o_regw=1; total 8 cycles.
- BEQ with i_br_taken=1 → o_pc_we=1 and o_pc_sel=1 in cycle 3; no o_regw.
- i_imem_ready held 0 with MEM_WAIT_MAX=15 → S_TRAP after 15 wait cycles, o_timeout=1. Repeat with ready rising on the 15th cycle → no trap.
- Opcode 0x7F → o_illegal=1 after DECODE, stuck until i_rst; i_rst pulse → state S_FETCH, flags 0.
- MUL (funct7=0000001): ZY_MEXT_EN defined with i_alu_done after 5 cycles → o_regw follows. ZY_MEXT_EN undefined → o_illegal=1.
